mult64_reg_pp: RTL and testbench



---
 rtl/mult64_pkg.sv | 20 ++
 rtl/mult32x32_pp.sv | 10 +
 rtl/mult64_reg_pp.sv | 66 ++++++
 tb/tb_mult64_reg_pp.sv | 128 ++++++++++++
 4 files changed

// File: rtl/mult64_pkg.sv
// Shared widths and types for the 64x64 pipelined multiplier.
package mult64_pkg;
  localparam int DATA_W = 64;
  localparam int HALF_W = 32;
  localparam int PROD_W = 128;
  localparam int LAT    = 3;

  typedef logic [DATA_W-1:0] operand_t;
  typedef logic [HALF_W-1:0] half_t;
  typedef logic [DATA_W-1:0] pp_t;
  typedef logic [PROD_W-1:0] prod_t;

  // Weighted recombination of the four 32x32 partial products.
  function automatic prod_t combine_pp(input pp_t p00, input pp_t p01,
                                       input pp_t p10, input pp_t p11);
    prod_t mid;
    mid = prod_t'(p01) + prod_t'(p10);
    return (prod_t'(p11) << DATA_W) + (mid << HALF_W) + prod_t'(p00);
  endfunction
endpackage

// File: rtl/mult32x32_pp.sv
// Combinational 32x32 -> 64 unsigned partial-product multiplier.
module mult32x32_pp
  import mult64_pkg::*;
(
  input  half_t i_a,
  input  half_t i_b,
  output pp_t   o_p
);
  assign o_p = pp_t'(i_a) * pp_t'(i_b);
endmodule

// File: rtl/mult64_reg_pp.sv
// Three-stage pipelined unsigned 64x64 -> 128 multiplier.
// Optional feature macro: MULT64_REG_PP_CLR_EN enables the iClr flush.
module mult64_reg_pp
  import mult64_pkg::*;
(
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iEn,
  input  logic               iClr,
  input  logic [DATA_W-1:0]  iData0,
  input  logic [DATA_W-1:0]  iData1,
  output logic [PROD_W-1:0]  oData
);
  operand_t r_a;
  operand_t r_b;
  pp_t      r_pp00;
  pp_t      r_pp01;
  pp_t      r_pp10;
  pp_t      r_pp11;
  prod_t    r_prod;

  pp_t      w_pp00;
  pp_t      w_pp01;
  pp_t      w_pp10;
  pp_t      w_pp11;
  logic     w_clr;

`ifdef MULT64_REG_PP_CLR_EN
  assign w_clr = iClr;
`else
  // Port kept for interface compatibility; deliberately unconnected.
  logic w_unused_clr;
  assign w_unused_clr = iClr;
  assign w_clr        = 1'b0;
`endif

  mult32x32_pp u_pp00 (.i_a(r_a[HALF_W-1:0]),      .i_b(r_b[HALF_W-1:0]),      .o_p(w_pp00));
  mult32x32_pp u_pp01 (.i_a(r_a[HALF_W-1:0]),      .i_b(r_b[DATA_W-1:HALF_W]), .o_p(w_pp01));
  mult32x32_pp u_pp10 (.i_a(r_a[DATA_W-1:HALF_W]), .i_b(r_b[HALF_W-1:0]),      .o_p(w_pp10));
  mult32x32_pp u_pp11 (.i_a(r_a[DATA_W-1:HALF_W]), .i_b(r_b[DATA_W-1:HALF_W]), .o_p(w_pp11));

  // All pipeline stages: reset/clear flush, otherwise advance on enable or hold.
  always_ff @(posedge iClk) begin
    if (iRst || w_clr) begin
      r_a    <= '0;
      r_b    <= '0;
      r_pp00 <= '0;
      r_pp01 <= '0;
      r_pp10 <= '0;
      r_pp11 <= '0;
      r_prod <= '0;
    end else if (iEn) begin
      r_a    <= iData0;
      r_b    <= iData1;
      r_pp00 <= w_pp00;
      r_pp01 <= w_pp01;
      r_pp10 <= w_pp10;
      r_pp11 <= w_pp11;
      r_prod <= combine_pp(r_pp00, r_pp01, r_pp10, r_pp11);
    end else begin
      r_prod <= r_prod;
    end
  end

  assign oData = r_prod;
endmodule

// File: tb/tb_mult64_reg_pp.sv
// Randomized self-checking bench for mult64_reg_pp against a product shift-register model.
module tb_mult64_reg_pp;
`ifdef MULT64_REG_PP_CLR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          en;
  logic          clr;
  logic [63:0]   d0;
  logic [63:0]   d1;
  logic [127:0]  q;

  logic [127:0]  mdl [3];
  int            n_tests;
  int            n_fail;

  mult64_reg_pp dut (
    .iClk  (clk),
    .iRst  (rst),
    .iEn   (en),
    .iClr  (clr),
    .iData0(d0),
    .iData1(d1),
    .oData (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, update model at the edge, compare after the edge.
  task automatic step(input logic [63:0] a, input logic [63:0] b,
                      input logic e, input logic c, input logic r, input string tag);
    @(negedge clk);
    d0 = a; d1 = b; en = e; clr = c; rst = r;
    @(posedge clk);
    if (r || (CLR_EN && c)) begin
      for (int i = 0; i < 3; i++) mdl[i] = 128'd0;
    end else if (e) begin
      mdl[2] = mdl[1];
      mdl[1] = mdl[0];
      mdl[0] = {64'd0, a} * {64'd0, b};
    end
    #1;
    check(tag, q, mdl[2]);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  logic [63:0]  ca [4];
  logic [63:0]  cb [4];
  logic [127:0] cexp [4];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; en = 1'b0; clr = 1'b0; d0 = 64'd0; d1 = 64'd0;
    for (int i = 0; i < 3; i++) mdl[i] = 128'd0;

    // Reset held with nonzero operands and enable
    for (int i = 0; i < 5; i++) begin
      step(64'hDEAD_BEEF_1234_5678, 64'hCAFE_F00D_8765_4321, 1'b1, 1'b0, 1'b1, "reset");
      check("reset_zero", q, 128'd0);
    end

    step(64'd3, 64'd5, 1'b1, 1'b0, 1'b0, "first");
    step(64'd0, 64'd0, 1'b1, 1'b0, 1'b0, "first");
    step(64'd0, 64'd0, 1'b1, 1'b0, 1'b0, "first");
    check("first_15", q, 128'd15);

    // Corner products, back to back
    ca[0] = 64'hFFFF_FFFF_FFFF_FFFF; cb[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    ca[1] = 64'd0;                   cb[1] = 64'h1234_5678_9ABC_DEF0;
    ca[2] = 64'd1;                   cb[2] = 64'h8000_0000_0000_0000;
    ca[3] = 64'h0000_0001_0000_0000; cb[3] = 64'h0000_0001_0000_0000;
    cexp[0] = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
    cexp[1] = 128'd0;
    cexp[2] = 128'h0000_0000_0000_0000_8000_0000_0000_0000;
    cexp[3] = 128'h0000_0000_0000_0001_0000_0000_0000_0000;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) step(ca[i], cb[i], 1'b1, 1'b0, 1'b0, "corner");
      else       step(64'd7, 64'd9, 1'b1, 1'b0, 1'b0, "corner");
      if (i >= 2) check("corner_const", q, cexp[i-2]);
    end

    for (int i = 0; i < 100; i++)
      step(rnd64(), rnd64(), 1'b1, 1'b0, 1'b0, "random");

    // Stall mid-stream: held output, then in-order drain
    for (int i = 0; i < 3; i++) step(rnd64(), rnd64(), 1'b1, 1'b0, 1'b0, "pre_stall");
    for (int i = 0; i < 4; i++) step(rnd64(), rnd64(), 1'b0, 1'b0, 1'b0, "stall");
    for (int i = 0; i < 4; i++) step(rnd64(), rnd64(), 1'b1, 1'b0, 1'b0, "drain");

    // Clear while enabled and full
    for (int i = 0; i < 3; i++) step(rnd64() | 64'd1, rnd64() | 64'd1, 1'b1, 1'b0, 1'b0, "pre_clr");
    step(rnd64(), rnd64(), 1'b1, 1'b1, 1'b0, "clr_en");
    if (CLR_EN) check("clr_zero", q, 128'd0);
    for (int i = 0; i < 4; i++) step(rnd64() | 64'd1, rnd64() | 64'd1, 1'b1, 1'b0, 1'b0, "post_clr");

    // Clear with enable low
    for (int i = 0; i < 3; i++) step(rnd64() | 64'd1, rnd64() | 64'd1, 1'b1, 1'b0, 1'b0, "pre_clr2");
    step(rnd64(), rnd64(), 1'b0, 1'b1, 1'b0, "clr_noen");
    if (CLR_EN) check("clr_noen_zero", q, 128'd0);
    for (int i = 0; i < 4; i++) step(rnd64(), rnd64(), 1'b1, 1'b0, 1'b0, "post_clr2");

    // Reset mid-stream
    step(rnd64(), rnd64(), 1'b1, 1'b0, 1'b1, "rst_mid");
    check("rst_mid_zero", q, 128'd0);
    for (int i = 0; i < 20; i++)
      step(rnd64(), rnd64(), ($urandom_range(0, 3) != 0), 1'b0, 1'b0, "tail");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
